// File: rtl/acc_offl_responder.sv
// rtl/acc_offl_responder.sv - accelerator-side offload endpoint: request FIFO, in-order issue, single writeback
// Optional ACC_OFFL_TIMEOUT_EN adds a WAIT-state watchdog that returns an error writeback.
module acc_offl_responder #(
  parameter int DataWidth     = 32,
  parameter int NumRs         = 3,
  parameter int QueueDepth    = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [31:0]                req_instr_i,
  input  logic [NumRs*DataWidth-1:0] req_rs_i,
  input  logic [4:0]                 req_rd_i,
  input  logic [1:0]                 req_writeback_i,
  output logic                       acc_valid_o,
  input  logic                       acc_ready_i,
  output logic [31:0]                acc_instr_o,
  output logic [NumRs*DataWidth-1:0] acc_rs_o,
  input  logic                       acc_rsp_valid_i,
  input  logic [DataWidth-1:0]       acc_rsp_data_i,
  input  logic                       acc_rsp_error_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [4:0]                 rsp_rd_o,
  output logic [DataWidth-1:0]       rsp_data_o,
  output logic                       rsp_error_o,
  output logic                       busy_o
);

  localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int CntW = $clog2(QueueDepth + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0]                r_instr [QueueDepth];
  logic [NumRs*DataWidth-1:0] r_rs    [QueueDepth];
  logic [4:0]                 r_rd    [QueueDepth];
  logic [1:0]                 r_wb    [QueueDepth];

  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 r_req_ready;
  state_t               r_state;
  logic [4:0]           r_rsp_rd;
  logic [DataWidth-1:0] r_rsp_data;
  logic                 r_rsp_error;

`ifdef ACC_OFFL_TIMEOUT_EN
  localparam int TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [TmrW-1:0] r_timer;
`endif

  logic            w_empty;
  logic            w_acc_valid;
  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_next;
  logic [PtrW-1:0] w_wr_ptr_next;
  logic [PtrW-1:0] w_rd_ptr_next;

  assign w_empty       = (r_count == '0);
  assign w_acc_valid   = (r_state == S_IDLE) && !w_empty;
  assign w_push        = req_valid_i && r_req_ready;
  assign w_pop         = w_acc_valid && acc_ready_i;
  assign w_count_next  = r_count + CntW'(w_push) - CntW'(w_pop);
  assign w_wr_ptr_next = (r_wr_ptr == PtrW'(QueueDepth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
  assign w_rd_ptr_next = (r_rd_ptr == PtrW'(QueueDepth - 1)) ? '0 : r_rd_ptr + PtrW'(1);

  // Storage needs no reset: entries are only observable while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= req_instr_i;
      r_rs[r_wr_ptr]    <= req_rs_i;
      r_rd[r_wr_ptr]    <= req_rd_i;
      r_wb[r_wr_ptr]    <= req_writeback_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
      r_state     <= S_IDLE;
      r_rsp_rd    <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
`ifdef ACC_OFFL_TIMEOUT_EN
      r_timer     <= '0;
`endif
    end else begin
      r_count     <= w_count_next;
      // Ready is registered, so a pop only frees space for the following cycle.
      r_req_ready <= (w_count_next != CntW'(QueueDepth));
      if (w_push) r_wr_ptr <= w_wr_ptr_next;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_next;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_rsp_rd <= r_rd[r_rd_ptr];
            if (r_wb[r_rd_ptr] != 2'b00) begin
              r_state <= S_WAIT;
`ifdef ACC_OFFL_TIMEOUT_EN
              r_timer <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (acc_rsp_valid_i) begin
            r_rsp_data  <= acc_rsp_data_i;
            r_rsp_error <= acc_rsp_error_i;
            r_state     <= S_RESP;
          end
`ifdef ACC_OFFL_TIMEOUT_EN
          else if (r_timer == TmrW'(TimeoutCycles - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + TmrW'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign acc_valid_o = w_acc_valid;
  assign acc_instr_o = w_acc_valid ? r_instr[r_rd_ptr] : '0;
  assign acc_rs_o    = w_acc_valid ? r_rs[r_rd_ptr] : '0;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rd_o    = r_rsp_rd;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_error_o = r_rsp_error;
  assign busy_o      = !w_empty || (r_state != S_IDLE);

endmodule

// File: doc/acc_offl_responder.md
# acc_offl_responder

Accelerator-side endpoint of the offload interface. It accepts instructions that the core's offload predecoder has claimed, together with their resolved source operands, and buffers them in a small request FIFO. It issues them in order to the accelerator datapath and returns writeback results to the core's register-file write port. At most one writeback instruction is outstanding in the accelerator at any time.

## Interface
Parameters:
- `DataWidth`, 32: operand and result width.
- `NumRs`, 3: number of source operands carried per request.
- `QueueDepth`, 2: request FIFO entries; must be ≥1.
- `TimeoutCycles`, 1024: watchdog limit; used only when `ACC_OFFL_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  offload request valid.
- `req_ready_o`  out  1  request FIFO not full.
- `req_instr_i`  in  32  offloaded instruction word.
- `req_rs_i`  in  NumRs*DataWidth  operands; rs0 in the LSBs.
- `req_rd_i`  in  5  destination register.
- `req_writeback_i`  in  2  writeback flags, as produced by the predecoder; nonzero means a result is expected.
- `acc_valid_o`  out  1  issue to accelerator.
- `acc_ready_i`  in  1  accelerator accepts the issue.
- `acc_instr_o`  out  32  head instruction.
- `acc_rs_o`  out  NumRs*DataWidth  head operands.
- `acc_rsp_valid_i`  in  1  accelerator result valid; single-cycle pulse.
- `acc_rsp_data_i`  in  DataWidth  result data.
- `acc_rsp_error_i`  in  1  result error.
- `rsp_valid_o`  out  1  writeback to core valid.
- `rsp_ready_i`  in  1  core accepts the writeback.
- `rsp_rd_o`  out  5  writeback register.
- `rsp_data_o`  out  DataWidth  writeback data.
- `rsp_error_o`  out  1  writeback error.
- `busy_o`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
Request FIFO:
- Each entry holds instr, rs, rd and writeback.
- Push when `req_valid_i & req_ready_o`.
- `req_ready_o = !full`; a pop in the same cycle does not free space for a push.

FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - `acc_valid_o = !empty`; `acc_instr_o`/`acc_rs_o` show the FIFO head.
  - On `acc_valid_o & acc_ready_i`: pop the FIFO and latch rd into the holding register.
  - If the popped writeback ≠ 0, go to WAIT; otherwise stay in IDLE. Non-writeback instructions therefore issue back-to-back.
- WAIT:
  - `acc_valid_o = 0`.
  - On `acc_rsp_valid_i`: latch data and error, go to RESP.
- RESP:
  - `rsp_valid_o = 1`; `rsp_rd_o`, `rsp_data_o`, `rsp_error_o` are held stable until `rsp_ready_i`, then go to IDLE.
- `acc_rsp_valid_i` outside WAIT is ignored and dropped.
- Responses are never reordered; there is one writeback in flight at most.

## Timing
- Reset: FIFO empty, state IDLE. Every output is 0 (`req_ready_o` is 0 during reset, 1 the cycle after). Holding registers are 0.
- Reset mid-operation discards all buffered and in-flight state; a later accelerator response is ignored.
- No FIFO fall-through: a push in cycle N gives `acc_valid_o` in N+1 at the earliest.
- `acc_rsp_valid_i` in cycle M gives `rsp_valid_o` in M+1.
- `rsp_ready_i` asserted in the same cycle `rsp_valid_o` rises completes the transfer in that cycle. IDLE issue may resume the next cycle.
- All outputs are driven from registered state or FIFO contents; there are no input-to-output combinational paths except the `acc_ready_i`-dependent pop.
- Once raised, `acc_valid_o` and the head data stay stable until `acc_ready_i`.
- `busy_o` is registered-state derived and goes low the cycle after the last completion.

## Configuration
Macro: `ACC_OFFL_TIMEOUT_EN`.
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches `TimeoutCycles-1` with no `acc_rsp_valid_i`, go to RESP with `rsp_data_o = 0` and `rsp_error_o = 1`.
  - A response arriving in that same cycle wins over the timeout.
  - The counter width is `$clog2(TimeoutCycles)`.
- Undefined: no counter; WAIT persists until a response arrives.

## Test plan
- Push instr 0x0000_500B, writeback=0, with `acc_ready_i` = 1 → `acc_valid_o` one cycle later for one cycle; no `rsp_valid_o`; `busy_o` low afterward.
- Push 3 requests with `acc_ready_i` = 0 and QueueDepth=2 → `req_ready_o` drops after 2 pushes. Raise ready → in-order issue on consecutive cycles.
- Writeback request with rd=7; `acc_rsp_valid_i` with data 0xDEAD_BEEF; `rsp_ready_i` held 0 for 3 cycles → rsp_rd=7 and data 0xDEADBEEF stable for 4 cycles; no new issue until the transfer completes.
- `acc_rsp_valid_i` pulsed in IDLE → no `rsp_valid_o`, state unchanged.
- Assert `rst_i` while in WAIT, then send a response → all outputs 0; the response is ignored; the FIFO is empty.
- With `ACC_OFFL_TIMEOUT_EN` defined and TimeoutCycles=8, send no response → `rsp_valid_o` with error=1 and data=0 exactly 8 cycles after WAIT entry.
